// File: rtl/arbitre_bus_4x8.sv
// arbitre_bus_4x8
//    Round-robin arbiter for one shared 8-bit bus with four requesters
//    (a=0, b=1, c=2, d=3). The owner keeps the bus for a multi-beat
//    burst. It gives up the bus after a beat marked last, after
//    MAX_BURST beats, or when it drops req. On release, a pending
//    requester takes over on the same edge.
//
//    Ports
//       clk, rst_n      system clock, async active-low reset
//       req[3:0]        per-requester request
//       last[3:0]       current beat of requester i is its final beat
//       a, b, c, d      requester data words
//       ready           consumer accepts the presented beat
//       gnt[3:0]        registered one-hot grant, zero when idle
//       sel[1:0]        registered mux select (current/most recent owner)
//       s[7:0]          owner's word while busy, 8'h00 otherwise
//       valid           a beat is presented on s
//       busy            an owner holds the bus
//
//    state | meaning
//    IDLE  | no owner, gnt=0, waiting for any req
//    OWNED | requester sel owns the bus, gnt[sel]=1

module arbitre_bus_4x8 #(
   parameter int MAX_BURST = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] last,
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [7:0] c,
   input  logic [7:0] d,
   input  logic       ready,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic [7:0] s,
   output logic       valid,
   output logic       busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] ptr_q, ptr_d;
   logic [3:0] gnt_q, gnt_d;
   logic [4:0] cnt_q, cnt_d;

   logic [3:0] arb_mask;
   logic       arb_found;
   logic [1:0] arb_win;
   logic [1:0] arb_idx;
   logic       xfer;
   logic       burst_end;
   logic [5:0] cnt_inc;

   // Candidates for arbitration. While owned, this is only consulted on a
   // burst end, so the ending owner (gnt_q) is masked out of that one pick.
   always_comb begin
      arb_mask  = (state_q == OWNED) ? (req & ~gnt_q) : req;
      arb_found = 1'b0;
      arb_win   = ptr_q;
      arb_idx   = ptr_q;
      // Walk from farthest to nearest so the nearest set bit after ptr wins.
      for (int k = 3; k >= 0; k--) begin
         arb_idx = ptr_q + 2'(k);
         if (arb_mask[arb_idx]) begin
            arb_found = 1'b1;
            arb_win   = arb_idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      cnt_d     = cnt_q;
      xfer      = 1'b0;
      burst_end = 1'b0;
      cnt_inc   = {1'b0, cnt_q} + 6'd1;

      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d = OWNED;
               sel_d   = arb_win;
               gnt_d   = 4'b0001 << arb_win;
               ptr_d   = arb_win + 2'd1;
               cnt_d   = 5'd0;
            end
         end
         OWNED: begin
            xfer      = req[sel_q] & ready;
            // A dropped req with no transfer (abort) ends the burst as well.
            burst_end = ~req[sel_q]
                      | (xfer & (last[sel_q] | (cnt_inc == 6'(MAX_BURST))));
            if (burst_end) begin
               cnt_d = 5'd0;
               if (arb_found) begin
                  sel_d = arb_win;
                  gnt_d = 4'b0001 << arb_win;
                  ptr_d = arb_win + 2'd1;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
               end
            end else if (xfer) begin
               cnt_d = cnt_inc[4:0];
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         ptr_q   <= 2'd0;
         gnt_q   <= 4'b0000;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         cnt_q   <= cnt_d;
      end
   end

   logic [7:0] mux_out;

   always_comb begin
      case (sel_q)
         2'd0:    mux_out = a;
         2'd1:    mux_out = b;
         2'd2:    mux_out = c;
         default: mux_out = d;
      endcase
   end

   assign busy  = (state_q == OWNED);
   assign gnt   = gnt_q;
   assign sel   = sel_q;
   assign valid = busy & req[sel_q];
   assign s     = busy ? mux_out : 8'h00;

endmodule

// File: tb/tb_arbitre_bus_4x8.sv
module tb_arbitre_bus_4x8;

   localparam int MB = 4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] last;
   logic [7:0] a, b, c, d;
   logic       ready;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic [7:0] s;
   logic       valid;
   logic       busy;

   int checks = 0;
   int errors = 0;

   arbitre_bus_4x8 #(.MAX_BURST(MB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .last(last),
      .a(a), .b(b), .c(c), .d(d), .ready(ready),
      .gnt(gnt), .sel(sel), .s(s), .valid(valid), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic drive_quiet();
      req = 4'b0; last = 4'b0; ready = 1'b0;
      a = 8'h0; b = 8'h0; c = 8'h0; d = 8'h0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_quiet();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_quiet();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (gnt !== 4'b0)  begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
      checks++; if (sel !== 2'd0)  begin errors++; $display("FAIL reset_sel got %0d exp 0", sel); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      checks++; if (s !== 8'h00)   begin errors++; $display("FAIL reset_s got %h exp 00", s); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_grant();
      @(negedge clk);
      req = 4'b0100; c = 8'h5A; last = 4'b0100; ready = 1'b1;
      #1;
      checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL basic_pre_gnt got %b exp 0000", gnt); end
      @(negedge clk); #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL basic_gnt got %b exp 0100", gnt); end
      checks++; if (sel !== 2'd2)    begin errors++; $display("FAIL basic_sel got %0d exp 2", sel); end
      checks++; if (s !== 8'h5A)     begin errors++; $display("FAIL basic_s got %h exp 5a", s); end
      checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL basic_valid got %b exp 1", valid); end
      @(negedge clk);
      req = 4'b0; last = 4'b0;
      #1;
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL basic_rel_busy got %b exp 0", busy); end
      checks++; if (gnt !== 4'b0)   begin errors++; $display("FAIL basic_rel_gnt got %b exp 0000", gnt); end
      checks++; if (sel !== 2'd2)   begin errors++; $display("FAIL basic_rel_sel got %0d exp 2", sel); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_rel_valid got %b exp 0", valid); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g;
      apply_reset();
      req = 4'b1111; last = 4'b1111; ready = 1'b1;
      a = 8'hA0; b = 8'hB1; c = 8'hC2; d = 8'hD3;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk); #1;
         exp_g = 4'b0001 << (k % 4);
         checks++;
         if (gnt !== exp_g || busy !== 1'b1)
            begin errors++; $display("FAIL rr_gnt step %0d got %b busy %b exp %b busy 1", k, gnt, busy, exp_g); end
      end
      @(negedge clk);
      drive_quiet();
   endtask

   task automatic test_burst_cap();
      apply_reset();
      req = 4'b0011; last = 4'b0000; ready = 1'b1; a = 8'h11; b = 8'h22;
      for (int k = 0; k < MB; k++) begin
         @(negedge clk); #1;
         checks++;
         if (gnt !== 4'b0001 || valid !== 1'b1)
            begin errors++; $display("FAIL cap_owner0 beat %0d got gnt %b valid %b exp 0001 1", k, gnt, valid); end
      end
      @(negedge clk); #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL cap_handoff got %b exp 0010", gnt); end
      checks++; if (s !== 8'h22)     begin errors++; $display("FAIL cap_handoff_s got %h exp 22", s); end
      req = 4'b0000;
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cap_abort_idle got %b exp 0", busy); end
   endtask

   task automatic test_back_pressure();
      logic [4:0] pat;
      int acc;
      pat = 5'b11001;
      acc = 0;
      @(negedge clk);
      drive_quiet();
      req = 4'b1000; d = 8'hD0; ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ready   = pat[i];
         last[3] = (acc == 2);
         d       = 8'hD0 + 8'(acc);
         #1;
         checks++;
         if (gnt !== 4'b1000 || valid !== 1'b1 || s !== 8'hD0 + 8'(acc))
            begin errors++; $display("FAIL bp_cycle %0d got gnt %b valid %b s %h exp 1000 1 %h", i, gnt, valid, s, 8'hD0 + 8'(acc)); end
         if (ready) acc++;
      end
      @(negedge clk);
      req = 4'b0; last = 4'b0; ready = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release got busy %b exp 0", busy); end
   endtask

   task automatic test_abort();
      apply_reset();
      req = 4'b0110; last = 4'b0; ready = 1'b1; b = 8'h3C; c = 8'h4D;
      @(negedge clk); #1;
      checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL abort_first got %b exp 0010", gnt); end
      @(negedge clk);
      req = 4'b0100;
      #1;
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid); end
      @(negedge clk); #1;
      checks++; if (gnt !== 4'b0100 || sel !== 2'd2)
         begin errors++; $display("FAIL abort_move got gnt %b sel %0d exp 0100 2", gnt, sel); end
      checks++; if (s !== 8'h4D) begin errors++; $display("FAIL abort_s got %h exp 4d", s); end
      @(negedge clk);
      drive_quiet();
   endtask

   task automatic test_reset_mid_burst();
      @(negedge clk);
      req = 4'b1000; ready = 1'b0; d = 8'h77;
      @(negedge clk); #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmb_busy got %b exp 1", busy); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (gnt !== 4'b0)   begin errors++; $display("FAIL rmb_gnt got %b exp 0000", gnt); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmb_valid got %b exp 0", valid); end
      checks++; if (s !== 8'h00)    begin errors++; $display("FAIL rmb_s got %h exp 00", s); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b1111; last = 4'b1111; ready = 1'b1;
      @(negedge clk); #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmb_ptr got %b exp 0001", gnt); end
      @(negedge clk);
      drive_quiet();
   endtask

   // Reference: bus ownership expressed as "owner index or -1" plus the
   // round-robin pointer and the beat count of the current burst.
   int m_owner, m_sel, m_ptr, m_cnt;

   function automatic int pick(input logic [3:0] cand, input int from);
      for (int k = 0; k < 4; k++)
         if (cand[(from + k) % 4]) return (from + k) % 4;
      return -1;
   endfunction

   task automatic model_step();
      int w;
      logic xf, fin;
      logic [3:0] excl;
      if (m_owner < 0) begin
         w = pick(req, m_ptr);
         if (w >= 0) begin
            m_owner = w; m_sel = w; m_ptr = (w + 1) % 4; m_cnt = 0;
         end
      end else begin
         xf  = req[m_owner] && ready;
         fin = !req[m_owner] || (xf && (last[m_owner] || (m_cnt + 1 == MB)));
         if (fin) begin
            excl = req;
            excl[m_owner] = 1'b0;
            w = pick(excl, m_ptr);
            m_cnt = 0;
            if (w >= 0) begin
               m_owner = w; m_sel = w; m_ptr = (w + 1) % 4;
            end else begin
               m_owner = -1;
            end
         end else if (xf) begin
            m_cnt++;
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] e_gnt;
      logic       e_busy, e_valid;
      logic [7:0] e_s;
      logic [7:0] words [4];
      apply_reset();
      m_owner = -1; m_sel = 0; m_ptr = 0; m_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         for (int r = 0; r < 4; r++) begin
            req[r]  = ($urandom_range(0, 3) != 0);
            last[r] = ($urandom_range(0, 3) == 0);
         end
         ready = ($urandom_range(0, 9) < 7);
         a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
         words[0] = a; words[1] = b; words[2] = c; words[3] = d;
         #1;
         e_busy  = (m_owner >= 0);
         e_gnt   = e_busy ? (4'b0001 << m_owner) : 4'b0000;
         e_valid = e_busy && req[m_owner];
         e_s     = e_busy ? words[m_sel] : 8'h00;
         checks++;
         if (gnt !== e_gnt || sel !== 2'(m_sel) || busy !== e_busy || valid !== e_valid || s !== e_s)
            begin
               errors++;
               $display("FAIL rand cycle %0d got gnt %b sel %0d busy %b valid %b s %h exp %b %0d %b %b %h",
                        i, gnt, sel, busy, valid, s, e_gnt, m_sel, e_busy, e_valid, e_s);
            end
         model_step();
      end
      @(negedge clk);
      drive_quiet();
   endtask

   initial begin
      test_reset();
      test_basic_grant();
      test_round_robin();
      test_burst_cap();
      test_back_pressure();
      test_abort();
      test_reset_mid_burst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arbitre_bus_4x8.md
# arbitre_bus_4x8

Round-robin arbiter and sequencer that shares one 8-bit output bus between four requesters. It drives the select of the 4-way, 8-bit data multiplexer built from our routing library and issues one-hot grants. It locks the bus for a multi-beat burst and caps burst length for fairness. It sits between four producer units and a single consumer that uses a valid/ready handshake.

## Interface

Parameters:
- MAX_BURST, 16: maximum beats per grant before a forced re-arbitration; legal range 1..31.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request per requester; bit i for requester i (a=0, b=1, c=2, d=3).
- last  input  4  bit i marks requester i's current beat as the final beat of its burst.
- a, b, c, d  input  8 each  requester data words.
- ready  input  1  consumer accepts the presented beat this cycle.
- gnt  output  4  one-hot grant, registered; all zero when no owner.
- sel  output  2  mux select, registered; index of the current or most recent owner.
- s  output  8  bus data: the owner's word when busy, 8'h00 otherwise.
- valid  output  1  beat present on s.
- busy  output  1  an owner holds the bus.

## Operation

- States: IDLE (no owner) and OWNED (gnt[sel]=1, busy=1).
- Beat transfer: valid & ready on a rising edge. valid = busy & req[sel] (combinational). s = mux(sel) gated by busy.
- Round-robin pointer ptr (2 bits): the search order starts at ptr, then ptr+1, ptr+2, ptr+3 mod 4. The first set req bit wins.
- IDLE → OWNED: any req set. The winner w is registered into sel and gnt. ptr ← w+1 mod 4. Beat counter cnt ← 0.
- OWNED, each transfer: cnt ← cnt+1. The burst ends when the transferred beat has last[sel]=1 or cnt+1 == MAX_BURST.
- OWNED, burst end: re-arbitrate on the same edge, with the ending owner excluded from this one arbitration.
  - Another requester pending: grant it directly, with no idle cycle.
  - Otherwise: go to IDLE. gnt ← 0. sel holds its value.
- OWNED, req[sel] deasserted without a transfer (abort): treated as burst end on that edge, with the same re-arbitration rule.
- A requester that reached MAX_BURST without last may request again. It competes normally from the next arbitration onward.
- A new req arriving while OWNED has no effect until the current burst ends.
- cnt width: 5 bits, saturating compare against MAX_BURST; cnt never wraps.

## Timing

- Reset (asynchronous, any time including mid-burst): gnt=0, sel=0, ptr=0, cnt=0, state IDLE, busy=0, valid=0, s=8'h00.
  - The bus releases immediately. No beat completes on a reset edge.
  - After rst_n rises, the first arbitration occurs on the first clk edge that sees req.
- Grant latency: req sampled at edge N → gnt and busy high after edge N. valid follows in the same cycle if req is still high.
- Throughput: one beat per cycle while ready=1. Back-to-back owner hand-off has zero dead cycles.
- gnt, sel, and busy change only on clk edges or on reset. valid and s are combinational from registered state plus req and the data inputs.
- Producers hold data and last stable while gnt[i] & req[i] & !ready.

## Test plan

- Reset and basic grant:
  - Stimulus: rst_n low, then high; req=4'b0100, c=8'h5A, last[2]=1, ready=1.
  - Required: gnt=4'b0100 and sel=2 one edge after req; s=8'h5A and valid=1 for exactly one cycle; next edge busy=0, gnt=0, sel stays 2.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held; every beat has last=1; ready=1.
  - Required: grant order 0,1,2,3,0,… with one owner per cycle and no idle cycle between owners.
- Burst cap:
  - Stimulus: MAX_BURST=4; req=4'b0011; requester 0 never asserts last; ready=1.
  - Required: requester 0 owns for exactly 4 beats; requester 1 is granted on the next edge.
- Back-pressure:
  - Stimulus: owner 3 with a 3-beat burst; ready toggles 1,0,0,1,1.
  - Required: beats complete only on ready cycles; s holds the owner's word during stalls; release after the 3rd accepted beat.
- Abort and reset mid-burst:
  - Abort stimulus: req[1] drops mid-burst while req[2]=1. Required: gnt moves to 4'b0100 on that edge.
  - Reset stimulus: rst_n pulses low mid-burst. Required: gnt=0 and valid=0 immediately; ptr=0 after release.
